// File: rtl/fsk_demod.sv
// FSK demodulator: synchronises and deglitches the squared coil signal, measures carrier
// periods and majority-votes them into bits. Optional glitch statistics: FSK_DEMOD_STATS_EN.
module fsk_demod #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int SYMBOL_PERIODS = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_enable,
  input  logic        i_coil,
  input  logic [31:0] i_thresh,
  output logic [31:0] o_period,
  output logic        o_period_valid,
  output logic        o_bit,
  output logic        o_bit_valid,
  output logic        o_carrier_lost,
  output logic [15:0] o_glitch_cnt
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int SW = $clog2(SYMBOL_PERIODS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     sync, filt, filt_q, rise, expire;
  logic [FW-1:0]            flt_cnt;
  logic [31:0]              period_cnt;
  logic [TW-1:0]            to_cnt;
  logic [SW-1:0]            sym_cnt, ones_cnt, ones_nxt;
  logic                     hit, sym_done, bit_val;

  assign sync = sync_q[SYNC_STAGES-1];
  // The rise is taken from the registered level so every edge sees the same fixed latency.
  assign rise = filt & ~filt_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update from
  // pre-edge values; blocking here would make the synchroniser collapse into one stage.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sync_q  <= '0;
      filt    <= 1'b0;
      filt_q  <= 1'b0;
      flt_cnt <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_coil};
      filt_q <= filt;
      if (sync != filt) begin
        if (flt_cnt == FW'(FILTER_LEN - 1)) begin
          filt    <= sync;
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + FW'(1);
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (!i_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ACQUIRE;
        ACQUIRE: if (rise) state_d = TRACK;
        TRACK:   if (expire) state_d = ACQUIRE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A rise in the expiry cycle wins over the timeout.
  assign expire   = (state_q != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES)) && !rise;
  assign hit      = (period_cnt < i_thresh);
  assign ones_nxt = ones_cnt + SW'(hit);
  assign sym_done = (sym_cnt == SW'(SYMBOL_PERIODS - 1));
  assign bit_val  = ({ones_nxt, 1'b0} > (SW + 1)'(SYMBOL_PERIODS));

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_period       <= '0;
      o_period_valid <= 1'b0;
      o_bit          <= 1'b0;
      o_bit_valid    <= 1'b0;
      o_carrier_lost <= 1'b0;
      period_cnt     <= '0;
      to_cnt         <= '0;
      sym_cnt        <= '0;
      ones_cnt       <= '0;
    end else begin
      o_period_valid <= 1'b0;
      o_bit_valid    <= 1'b0;
      if (!i_enable || state_q == IDLE) begin
        period_cnt     <= '0;
        to_cnt         <= '0;
        sym_cnt        <= '0;
        ones_cnt       <= '0;
        o_carrier_lost <= 1'b0;
      end else if (rise) begin
        period_cnt <= 32'd1;
        to_cnt     <= TW'(1);
        if (state_q == TRACK) begin
          o_period       <= period_cnt;
          o_period_valid <= 1'b1;
          o_carrier_lost <= 1'b0;
          if (sym_done) begin
            o_bit       <= bit_val;
            o_bit_valid <= 1'b1;
            sym_cnt     <= '0;
            ones_cnt    <= '0;
          end else begin
            sym_cnt  <= sym_cnt + SW'(1);
            ones_cnt <= ones_nxt;
          end
        end
      end else if (expire) begin
        // Carrier gone: drop the partial symbol and re-acquire.
        o_carrier_lost <= 1'b1;
        to_cnt         <= TW'(1);
        period_cnt     <= '0;
        sym_cnt        <= '0;
        ones_cnt       <= '0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
        if (state_q == TRACK && period_cnt != '1) period_cnt <= period_cnt + 32'd1;
      end
    end
  end

`ifdef FSK_DEMOD_STATS_EN
  logic glitch;
  // The input fell back to the filtered level before it was accepted.
  assign glitch = (sync == filt) && (flt_cnt != '0);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)                                    o_glitch_cnt <= '0;
    else if (glitch && o_glitch_cnt != 16'hFFFF)    o_glitch_cnt <= o_glitch_cnt + 16'd1;
  end
`else
  assign o_glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_fsk_demod.sv
// Directed bench for fsk_demod: period measurement, symbol voting, glitch rejection,
// carrier timeout, enable drop and reset mid-track, all against hand-derived values.
module tb_fsk_demod;

  localparam int LATENCY = 2 + 4 + 1;
`ifdef FSK_DEMOD_STATS_EN
  localparam int EXP_GLITCH = 1;
`else
  localparam int EXP_GLITCH = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        coil = 1'b0;
  logic [31:0] thresh = 32'd90;
  logic [31:0] period;
  logic        period_valid, bit_out, bit_valid, carrier_lost;
  logic [15:0] glitch_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] periods[$];
  int          pv_cyc[$];
  logic        bits[$];
  int          bv_idx[$];
  int          exp_q[$];
  int          rise_q[$];
  int          bv_orphan = 0;
  int          lost_rise_cyc = 0;
  int          lost_fall_cyc = 0;
  logic        lost_prev = 1'b0;

  fsk_demod dut (
    .i_clk          (clk),
    .i_nrst         (rst_n),
    .i_enable       (enable),
    .i_coil         (coil),
    .i_thresh       (thresh),
    .o_period       (period),
    .o_period_valid (period_valid),
    .o_bit          (bit_out),
    .o_bit_valid    (bit_valid),
    .o_carrier_lost (carrier_lost),
    .o_glitch_cnt   (glitch_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampling 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (period_valid) begin
      periods.push_back(period);
      pv_cyc.push_back(cyc);
    end
    if (bit_valid) begin
      bits.push_back(bit_out);
      bv_idx.push_back(periods.size());
      if (!period_valid) bv_orphan++;
    end
    if (carrier_lost && !lost_prev) lost_rise_cyc = cyc;
    if (!carrier_lost && lost_prev) lost_fall_cyc = cyc;
    lost_prev = carrier_lost;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    periods.delete();
    pv_cyc.delete();
    bits.delete();
    bv_idx.delete();
    exp_q.delete();
    rise_q.delete();
  endtask

  // n square-wave periods of p cycles, starting with a rise; called and returns at a negedge.
  task automatic wave(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      coil = 1'b1;
      rise_q.push_back(cyc);
      exp_q.push_back(p);
      repeat (p / 2) @(negedge clk);
      coil = 1'b0;
      repeat (p - p / 2) @(negedge clk);
    end
  endtask

  // 100-cycle period with a 2-cycle high glitch inside the low phase.
  task automatic glitch_wave();
    coil = 1'b1;
    rise_q.push_back(cyc);
    exp_q.push_back(100);
    repeat (50) @(negedge clk);
    coil = 1'b0;
    repeat (20) @(negedge clk);
    coil = 1'b1;
    repeat (2) @(negedge clk);
    coil = 1'b0;
    repeat (28) @(negedge clk);
  endtask

  task automatic check_periods(input string tag, input int n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_p%0d", tag, i), periods[i], exp_q[i]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_period", period, 0);
    check("rst_pvalid", period_valid, 0);
    check("rst_bit", bit_out, 0);
    check("rst_bvalid", bit_valid, 0);
    check("rst_lost", carrier_lost, 0);
    check("rst_glitch", glitch_cnt, 0);

    rst_n = 1'b1;
    enable = 1'b1;
    repeat (5) @(negedge clk);

    // Symbols: 8x100 (one with glitch) -> 0; 5x80+3x100 -> 1; 4x80+4x100 -> 0 (tie).
    wave(100, 4);
    glitch_wave();
    wave(100, 3);
    wave(80, 5);
    wave(100, 3);
    wave(80, 4);
    wave(100, 4);
    // Three more periods, then the carrier stops.
    wave(100, 3);
    repeat (4200) @(negedge clk);

    check("a_npv", periods.size(), 26);
    check_periods("a", 26);
    check("a_nbits", bits.size(), 3);
    check("a_bit0", bits[0], 0);
    check("a_bit1", bits[1], 1);
    check("a_bit2_tie", bits[2], 0);
    check("a_bidx0", bv_idx[0], 8);
    check("a_bidx1", bv_idx[1], 16);
    check("a_bidx2", bv_idx[2], 24);
    check("a_orphan_bv", bv_orphan, 0);
    check("a_glitch", glitch_cnt, EXP_GLITCH);
    check("a_first_lat", pv_cyc[0] - rise_q[1], LATENCY);
    check("b_lost", carrier_lost, 1);
    check("b_lost_delay", lost_rise_cyc - pv_cyc[25], 4096);

    // Carrier resumes: 8x80 -> 1, then 5 periods of a new symbol before enable drops.
    clear_logs();
    wave(80, 8);
    wave(80, 6);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    check("c_lost_clr", lost_fall_cyc, pv_cyc[0]);
    check("c_lost_now", carrier_lost, 0);
    check("c_npv", periods.size(), 13);
    check_periods("c", 13);
    check("c_nbits", bits.size(), 1);
    check("c_bit", bits[0], 1);
    check("c_bidx", bv_idx[0], 8);
    check("d_hold_period", period, 80);
    check("d_hold_bit", bit_out, 1);

    // Re-enabled: partial symbol gone, a full 8 periods of 100 -> 0.
    clear_logs();
    enable = 1'b1;
    repeat (5) @(negedge clk);
    wave(100, 9);
    repeat (20) @(negedge clk);
    check("d_npv", periods.size(), 8);
    check_periods("d", 8);
    check("d_nbits", bits.size(), 1);
    check("d_bit", bits[0], 0);
    check("d_bidx", bv_idx[0], 8);

    // Reset asserted asynchronously mid-track while the coil keeps toggling.
    coil = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("e_rst_period", period, 0);
    check("e_rst_bit", bit_out, 0);
    check("e_rst_glitch", glitch_cnt, 0);
    repeat (30) @(negedge clk);
    coil = 1'b0;
    repeat (40) @(negedge clk);
    coil = 1'b1;
    repeat (50) @(negedge clk);
    coil = 1'b0;
    repeat (50) @(negedge clk);
    check("e_rst_pvalid", period_valid, 0);
    check("e_rst_lost", carrier_lost, 0);
    clear_logs();
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    wave(100, 1);
    check("e_no_pv_first_rise", periods.size(), 0);
    wave(100, 2);
    repeat (20) @(negedge clk);
    check("e_npv", periods.size(), 2);
    check_periods("e", 2);
    check("e_lat", pv_cyc[0] - rise_q[1], LATENCY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
